// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator: default widths,
// FSM state encoding and the resolver chunk-count helper.
package csa_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ACC_WIDTH = 16;
  localparam int DEF_CHUNK     = 4;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } csa_state_e;

  // Number of carry-propagate steps needed to resolve the accumulator.
  function automatic int num_chunks(input int acc_width, input int chunk);
    return acc_width / chunk;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One 3:2 compression row: no carry propagation, the carry vector is
// pre-shifted into its next-higher weight and the bit pushed out of the
// top is reported separately so the caller can track overflow.
module csa_row #(
  parameter int ACC_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  input  logic [ACC_WIDTH-1:0] c,
  output logic [ACC_WIDTH-1:0] sum,
  output logic [ACC_WIDTH-1:0] carry_shifted,
  output logic                 carry_msb
);

  logic [ACC_WIDTH-1:0] w_maj;

  // Bitwise full-adder: parity is the sum, majority is the carry.
  always_comb begin
    w_maj         = (a & b) | (a & c) | (b & c);
    sum           = a ^ b ^ c;
    carry_shifted = {w_maj[ACC_WIDTH-2:0], 1'b0};
    carry_msb     = w_maj[ACC_WIDTH-1];
  end

endmodule

// File: rtl/csa_accumulator.sv
// Streaming accumulator holding its running total in carry-save form.
// Operands are compressed one per cycle; on the last beat of a packet the
// sum/carry pair is resolved CHUNK bits per cycle and presented on a
// valid/ready output together with a sticky overflow flag.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_ACCUM   | accepting operands, compressing into S/C
// ST_RESOLVE | rippling S+C one chunk per cycle into the result
// ST_OUTPUT  | result held on out_data until out_ready
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CHUNK     = DEF_CHUNK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_overflow,
  output logic                 busy
);

  localparam int NCH   = num_chunks(ACC_WIDTH, CHUNK);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  if (ACC_WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("csa_accumulator: ACC_WIDTH must be a multiple of CHUNK");
  end
  if (ACC_WIDTH < WIDTH) begin : g_bad_width
    $error("csa_accumulator: ACC_WIDTH must be >= WIDTH");
  end

  csa_state_e           r_state;
  logic [ACC_WIDTH-1:0] r_s;
  logic [ACC_WIDTH-1:0] r_c;
  logic                 r_ovf;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_cc;
  logic [ACC_WIDTH-1:0] r_res;
  logic                 r_res_ovf;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [ACC_WIDTH-1:0] w_x;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_carry;
  logic                 w_carry_msb;
  logic [CHUNK-1:0]     w_s_k;
  logic [CHUNK-1:0]     w_c_k;
  logic [CHUNK:0]       w_csum;
  logic                 w_last_chunk;

  assign w_x = ACC_WIDTH'(in_data);

  csa_row #(.ACC_WIDTH(ACC_WIDTH)) u_row (
    .a             (r_s),
    .b             (r_c),
    .c             (w_x),
    .sum           (w_sum),
    .carry_shifted (w_carry),
    .carry_msb     (w_carry_msb)
  );

  // Chunk adder for the resolver: current slice of S and C plus the ripple carry.
  always_comb begin
    w_s_k        = r_s[int'(r_idx)*CHUNK +: CHUNK];
    w_c_k        = r_c[int'(r_idx)*CHUNK +: CHUNK];
    w_csum       = {1'b0, w_s_k} + {1'b0, w_c_k} + {{CHUNK{1'b0}}, r_cc};
    w_last_chunk = (r_idx == IDX_W'(NCH - 1));
  end

  // Control FSM with registered handshake/status outputs and datapath updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_s         <= '0;
      r_c         <= '0;
      r_ovf       <= 1'b0;
      r_idx       <= '0;
      r_cc        <= 1'b0;
      r_res       <= '0;
      r_res_ovf   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (in_valid && r_in_ready) begin
            r_s   <= w_sum;
            r_c   <= w_carry;
            r_ovf <= r_ovf | w_carry_msb;
            if (in_last) begin
              r_state    <= ST_RESOLVE;
              r_idx      <= '0;
              r_cc       <= 1'b0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        ST_RESOLVE: begin
          r_res[int'(r_idx)*CHUNK +: CHUNK] <= w_csum[CHUNK-1:0];
          r_cc  <= w_csum[CHUNK];
          r_idx <= r_idx + 1'b1;
          if (w_last_chunk) begin
            r_ovf       <= r_ovf | w_csum[CHUNK];
            r_res_ovf   <= r_ovf | w_csum[CHUNK];
            r_state     <= ST_OUTPUT;
            r_out_valid <= 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            r_s         <= '0;
            r_c         <= '0;
            r_ovf       <= 1'b0;
            r_state     <= ST_ACCUM;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_res;
  assign out_overflow = r_res_ovf;
  assign busy         = r_busy;

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: a packet-level model (plain integer sum per
// packet, fixed resolve latency) checked every cycle, plus directed
// packets with hand-computed results and randomized traffic.
module tb_csa_accumulator;

  localparam int W   = 8;
  localparam int AW  = 16;
  localparam int CH  = 4;
  localparam int LAT = AW / CH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_data;
  logic          out_overflow;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  csa_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .CHUNK(CH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired at t=%0t", name, $time);
  endtask

  // ---------------- packet-level reference model ----------------
  longint         m_total = 0;
  bit             m_inflight = 1'b0;
  int             cyc = 0;
  int             m_valid_cyc = 0;
  logic [AW-1:0]  m_exp_data = '0;
  bit             m_exp_ovf = 1'b0;
  bit             e_rdy, e_ov;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_total    = 0;
      m_inflight = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end else begin
      cyc++;
      e_rdy = !m_inflight;
      e_ov  = m_inflight && (cyc >= m_valid_cyc);
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("busy", 32'(busy), 32'(m_inflight));
      if (e_ov) begin
        chk("out_data", 32'(out_data), 32'(m_exp_data));
        chk("out_overflow", 32'(out_overflow), 32'(m_exp_ovf));
      end
      if (in_valid && e_rdy) begin
        m_total += longint'(in_data);
        if (in_last) begin
          m_inflight  = 1'b1;
          m_valid_cyc = cyc + LAT + 1;
          m_exp_data  = m_total[AW-1:0];
          m_exp_ovf   = (m_total >= (64'd1 << AW));
          m_total     = 0;
        end
      end
      if (e_ov && out_ready) m_inflight = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [W-1:0] d, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 300) begin
        timeout("send");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input int hold, output logic [AW-1:0] d, output logic o);
    int n = 0;
    out_ready = (hold == 0);
    @(negedge clk);
    while (!out_valid) begin
      n++;
      if (n > 100) begin
        timeout("get_result");
        break;
      end
      @(negedge clk);
    end
    d = out_data;
    o = out_overflow;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] d;
    logic          o;
    int            n;

    // Reset and release
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // 0x1B + 0x35 + 0x55 = 0xA5 with exact output timing
    out_ready = 1'b1;
    send(8'h1B, 1'b0);
    send(8'h35, 1'b0);
    send(8'h55, 1'b1);
    repeat (LAT) @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'h00A5);
    chk("t2_ovf", 32'(out_overflow), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("t2_valid_one_cycle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-resolve, with no clock edge
    send(8'h10, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_out_ovf", 32'(out_overflow), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0xFF + 0x01 + 0x01 = 0x101, then single beat 0x07
    send(8'hFF, 1'b0);
    send(8'h01, 1'b0);
    send(8'h01, 1'b1);
    get_result(0, d, o);
    chk("t3_data", 32'(d), 32'h0101);
    chk("t3_ovf", 32'(o), 32'd0);
    send(8'h07, 1'b1);
    get_result(0, d, o);
    chk("t3_single", 32'(d), 32'h0007);

    // 258 x 0xFF = 65790 -> wraps to 0xFE with overflow; next packet clean
    for (int i = 0; i < 258; i++) send(8'hFF, i == 257);
    get_result(0, d, o);
    chk("t4_data", 32'(d), 32'h00FE);
    chk("t4_ovf", 32'(o), 32'd1);
    send(8'h01, 1'b1);
    get_result(0, d, o);
    chk("t4_next_data", 32'(d), 32'h0001);
    chk("t4_next_ovf", 32'(o), 32'd0);

    // Backpressure with a waiting operand
    out_ready = 1'b0;
    send(8'h20, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) timeout("t5_wait_valid");
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_in_ready_low", 32'(in_ready), 32'd0);
      chk("t5_data_hold", 32'(out_data), 32'h0020);
      chk("t5_ovf_hold", 32'(out_overflow), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("t5_in_ready_rise", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    get_result(0, d, o);
    chk("t5_next_data", 32'(d), 32'h0033);

    // Reset during resolve discards the pending result
    send(8'h44, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("t6_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'h02, 1'b1);
    get_result(0, d, o);
    chk("t6_data", 32'(d), 32'h0002);
    chk("t6_ovf", 32'(o), 32'd0);

    // Randomized packets, gaps and backpressure; the model checks values
    for (int p = 0; p < 30; p++) begin
      int len;
      bool_heavy: begin end
      if (p % 6 == 0) begin
        len = $urandom_range(250, 262);
        for (int i = 0; i < len; i++) send(8'($urandom_range(200, 255)), i == len - 1);
      end else begin
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
          send(8'($urandom), i == len - 1);
          if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
        end
      end
      get_result($urandom_range(0, 3), d, o);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
